// File: rtl/strip_trigger_decoder_pkg.sv
// ---------------------------------------------------------------------------
// strip_trigger_decoder_pkg
//   Shared definitions for the strip trigger link: frame length, payload
//   field positions, parity bit index and decoder FSM encodings. The trigger
//   generator imports the same package so field packing is single-sourced.
// ---------------------------------------------------------------------------
package strip_trigger_decoder_pkg;

    // Beats per frame; two payload bits per beat.
    localparam int FRAME_CYCLES_DEF = 13;
    localparam int PAYLOAD_W        = 2 * FRAME_CYCLES_DEF;

    // Payload[25:0] = {par, phi_id[4:0], band_id[7:0], bcid[11:0]}
    localparam int BCID_LSB = 0;
    localparam int BCID_MSB = 11;
    localparam int BAND_LSB = 12;
    localparam int BAND_MSB = 19;
    localparam int PHI_LSB  = 20;
    localparam int PHI_MSB  = 24;
    localparam int PAR_BIT  = 25;

    // Decoder FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [4:0]  phi_id;
        logic [7:0]  band_id;
        logic [11:0] bcid;
    } trig_fields_t;

    // Even parity over everything below the parity bit.
    function automatic logic payload_parity(input logic [PAYLOAD_W-1:0] p);
        return ^p[PAR_BIT-1:0];
    endfunction

endpackage

// File: rtl/strip_trigger_decoder_stat_cnt.sv
// ---------------------------------------------------------------------------
// strip_trigger_decoder_stat_cnt
//   Saturating event counter with synchronous clear.
//   Ports:
//     clk    in  clock
//     reset  in  synchronous active-high reset (count -> 0)
//     i_clr  in  synchronous clear; wins over a same-cycle increment
//     i_inc  in  count one event
//     o_cnt  out current count, sticks at all-ones
// ---------------------------------------------------------------------------
module strip_trigger_decoder_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/strip_trigger_decoder.sv
// ---------------------------------------------------------------------------
// strip_trigger_decoder
//   Receive end of the strip trigger link. Recovers {bcid, phi_id, band_id}
//   frames from the trig_en / trig_d0 / trig_d1 lanes, checks frame length
//   and even parity, and keeps saturating good-frame / error statistics.
//   Ports:
//     clk, reset                 link clock, synchronous active-high reset
//     trig_en, trig_d0, trig_d1  frame enable and data lanes (d1 = high bit)
//     cnt_clear                  synchronous clear of frame_cnt / err_cnt
//     frame_valid                1-cycle pulse, good frame, fields updated
//     bcid, phi_id, band_id      decoded fields, held until next good frame
//     parity_err                 1-cycle pulse, full-length frame, bad parity
//     len_err                    1-cycle pulse, frame too short or too long
//     busy                       high in SHIFT or DRAIN
//     frame_cnt, err_cnt         saturating statistics
//     dbg_state                  current FSM state
//   No valid/ready handshake: the link is a free-running stream framed by
//   trig_en; every output pulse is a single clk wide and cannot be stalled.
// ---------------------------------------------------------------------------
module strip_trigger_decoder
    import strip_trigger_decoder_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trig_en,
    input  logic                 trig_d0,
    input  logic                 trig_d1,
    input  logic                 cnt_clear,
    output logic                 frame_valid,
    output logic [11:0]          bcid,
    output logic [4:0]           phi_id,
    output logic [7:0]           band_id,
    output logic                 parity_err,
    output logic                 len_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [1:0]           dbg_state
);

    localparam int PW = 2 * FRAME_CYCLES;
    localparam int BW = $clog2(FRAME_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_CYCLES);

    // Input stage
    logic r_en, r_d0, r_d1;

    // FSM and datapath
    logic          r_armed;     // low for the first cycle after reset
    logic [1:0]    r_state;
    logic [BW-1:0] r_beat_cnt;
    logic [PW-1:0] r_shreg;
    logic          r_len_pend;
    logic          r_frame_valid;
    logic          r_parity_err;
    logic          r_len_err;
    trig_fields_t  r_fields;

    logic [1:0]    w_state_nxt;
    logic [BW-1:0] w_beat_nxt;
    logic [PW-1:0] w_shreg_nxt;
    logic          w_par_ok;
    logic          w_good;
    logic          w_bad_par;
    logic          w_len_evt;
    logic          w_err_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en <= 1'b0;
            r_d0 <= 1'b0;
            r_d1 <= 1'b0;
        end else begin
            r_en <= trig_en;
            r_d0 <= trig_d0;
            r_d1 <= trig_d1;
        end
    end

    assign w_par_ok = (r_shreg[PAR_BIT] == payload_parity(r_shreg));

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_shreg_nxt = r_shreg;
        w_good      = 1'b0;
        w_bad_par   = 1'b0;
        w_len_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_en) begin
                    w_state_nxt = ST_SHIFT;
                    w_beat_nxt  = BW'(1);
                    w_shreg_nxt = {{(PW-2){1'b0}}, r_d1, r_d0};
                end
            end
            ST_SHIFT: begin
                if (r_en) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        // 14th beat: frame too long, swallow the rest
                        w_len_evt   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_beat_nxt  = r_beat_cnt + 1'b1;
                        w_shreg_nxt = {r_shreg[PW-3:0], r_d1, r_d0};
                    end
                end else if (r_beat_cnt == LAST_BEAT) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_len_evt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_good    = w_par_ok;
                w_bad_par = ~w_par_ok;
                // en high here is the first beat of a zero-gap follow-on frame
                if (r_en) begin
                    w_state_nxt = ST_SHIFT;
                    w_beat_nxt  = BW'(1);
                    w_shreg_nxt = {{(PW-2){1'b0}}, r_d1, r_d0};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!r_en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed       <= 1'b0;
            r_state       <= ST_IDLE;
            r_beat_cnt    <= '0;
            r_shreg       <= '0;
            r_len_pend    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_parity_err  <= 1'b0;
            r_len_err     <= 1'b0;
            r_fields      <= '0;
        end else begin
            r_armed <= 1'b1;
            if (!r_armed) begin
                // First post-reset sample: if a frame is already running we
                // must not decode its tail, so sit in DRAIN until en drops.
                r_state    <= trig_en ? ST_DRAIN : ST_IDLE;
                r_beat_cnt <= '0;
            end else begin
                r_state    <= w_state_nxt;
                r_beat_cnt <= w_beat_nxt;
                r_shreg    <= w_shreg_nxt;
            end
            // Length errors are detected one cycle earlier than the CHECK
            // result, so they take one extra stage to line up the latency.
            r_len_pend    <= w_len_evt;
            r_len_err     <= r_len_pend;
            r_frame_valid <= w_good;
            r_parity_err  <= w_bad_par;
            if (w_good) begin
                r_fields.bcid    <= r_shreg[BCID_MSB:BCID_LSB];
                r_fields.band_id <= r_shreg[BAND_MSB:BAND_LSB];
                r_fields.phi_id  <= r_shreg[PHI_MSB:PHI_LSB];
            end
        end
    end

    // Counters step on the same edge that raises the matching pulse.
    assign w_err_inc = w_bad_par | r_len_pend;

    strip_trigger_decoder_stat_cnt #(.W(CNT_WIDTH)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (cnt_clear),
        .i_inc (w_good),
        .o_cnt (frame_cnt)
    );

    strip_trigger_decoder_stat_cnt #(.W(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (cnt_clear),
        .i_inc (w_err_inc),
        .o_cnt (err_cnt)
    );

    assign frame_valid = r_frame_valid;
    assign parity_err  = r_parity_err;
    assign len_err     = r_len_err;
    assign bcid        = r_fields.bcid;
    assign phi_id      = r_fields.phi_id;
    assign band_id     = r_fields.band_id;
    assign busy        = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_strip_trigger_decoder.sv
module tb_strip_trigger_decoder;

  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          trig_en, trig_d0, trig_d1, cnt_clear;
  logic          frame_valid, parity_err, len_err, busy;
  logic [11:0]   bcid;
  logic [4:0]    phi_id;
  logic [7:0]    band_id;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic [1:0]    dbg_state;

  strip_trigger_decoder #(.CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .trig_en     (trig_en),
    .trig_d0     (trig_d0),
    .trig_d1     (trig_d1),
    .cnt_clear   (cnt_clear),
    .frame_valid (frame_valid),
    .bcid        (bcid),
    .phi_id      (phi_id),
    .band_id     (band_id),
    .parity_err  (parity_err),
    .len_err     (len_err),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // pulse monitor
  int fv_n = 0, pe_n = 0, le_n = 0, viol_n = 0;
  always @(negedge clk) begin
    fv_n = fv_n + int'(frame_valid);
    pe_n = pe_n + int'(parity_err);
    le_n = le_n + int'(len_err);
    if ((int'(frame_valid) + int'(parity_err) + int'(len_err)) > 1) viol_n = viol_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] mk(input logic [11:0] b, input logic [4:0] ph,
                                     input logic [7:0] bd, input logic flip);
    logic [24:0] f;
    f = {ph, bd, b};
    return {(^f) ^ flip, f};
  endfunction

  // driver tasks
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trig_en = 1'b0;
      trig_d0 = 1'($urandom_range(0, 1));
      trig_d1 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_beat(input logic [25:0] p, input int i);
    logic [1:0] b;
    if (i < 13) b = p[25-2*i -: 2];
    else        b = 2'($urandom_range(0, 3));
    trig_en = 1'b1;
    trig_d1 = b[1];
    trig_d0 = b[0];
  endtask

  // nbeats of en=1, then returns at the negedge that drives the first en=0
  task automatic send_frame(input logic [25:0] p, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      drive_beat(p, i);
    end
    @(negedge clk);
    trig_en = 1'b0;
    trig_d0 = 1'($urandom_range(0, 1));
    trig_d1 = 1'($urandom_range(0, 1));
  endtask

  // kind: 0 frame_valid, 1 parity_err, 2 len_err; lat=-1 on timeout
  task automatic wait_pulse(input int kind, output int lat);
    logic hit;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      hit = (kind == 0) ? frame_valid : (kind == 1) ? parity_err : len_err;
      if (hit && lat < 0) lat = k;
      if (lat >= 0) break;
    end
  endtask

  initial begin
    int lat, fv0, pe0, le0, first_idx, second_idx, npulse, first_le;
    logic [11:0] a_bcid;
    logic busy_seen;
    logic [25:0] pa, pb;

    reset = 1'b1; trig_en = 1'b0; trig_d0 = 1'b0; trig_d1 = 1'b0; cnt_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_busy",        32'(busy),        32'h0);
    chk("rst_cnts",        32'({frame_cnt, err_cnt}), 32'h0);
    chk("rst_fields",      32'({bcid, phi_id, band_id}), 32'h0);
    reset = 1'b0;
    idle_cycles(3);
    chk("idle_state", 32'(dbg_state), 32'h0);

    // 1. good frame
    send_frame(mk(12'hABC, 5'h13, 8'h5A, 1'b0), 13);
    wait_pulse(0, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_bcid",    32'(bcid),    32'hABC);
    chk("t1_phi",     32'(phi_id),  32'h13);
    chk("t1_band",    32'(band_id), 32'h5A);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_err_cnt",   32'(err_cnt),   32'd0);
    idle_cycles(3);

    // 2. bad parity
    fv0 = fv_n;
    send_frame(mk(12'hABC, 5'h13, 8'h5A, 1'b1), 13);
    wait_pulse(1, lat);
    chk("t2_latency", 32'(lat), 32'd3);
    idle_cycles(3);
    chk("t2_fields_held", 32'({bcid, phi_id, band_id}), 32'({12'hABC, 5'h13, 8'h5A}));
    chk("t2_err_cnt",     32'(err_cnt), 32'd1);
    chk("t2_no_valid",    32'(fv_n - fv0), 32'd0);

    // 3a. short frame
    le0 = le_n;
    send_frame(mk(12'h111, 5'h01, 8'h11, 1'b0), 12);
    wait_pulse(2, lat);
    chk("t3_short_latency", 32'(lat), 32'd3);
    idle_cycles(3);
    chk("t3_short_count", 32'(le_n - le0), 32'd1);

    // 3b. long frame: 20 beats
    le0 = le_n; fv0 = fv_n; pe0 = pe_n;
    first_le = -1;
    pa = mk(12'h222, 5'h02, 8'h22, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (len_err && first_le < 0) first_le = i;
      drive_beat(pa, i);
    end
    @(negedge clk);
    chk("t3_long_busy", 32'(busy), 32'h1);
    chk("t3_long_pulse_beat", 32'(first_le), 32'd16);
    trig_en = 1'b0;
    idle_cycles(5);
    chk("t3_long_idle", 32'(busy), 32'h0);
    chk("t3_long_count", 32'(le_n - le0), 32'd1);
    chk("t3_long_other", 32'((fv_n - fv0) + (pe_n - pe0)), 32'd0);
    chk("t3_err_cnt", 32'(err_cnt), 32'd3);

    // 4. zero-gap back-to-back
    pa = mk(12'h123, 5'h1F, 8'hFF, 1'b0);
    pb = mk(12'hFFF, 5'h00, 8'h81, 1'b0);
    first_idx = -1; second_idx = -1; npulse = 0; a_bcid = '0;
    for (int idx = 0; idx < 36; idx++) begin
      @(negedge clk);
      if (frame_valid) begin
        npulse++;
        if (npulse == 1) begin first_idx = idx; a_bcid = bcid; end
        if (npulse == 2) second_idx = idx;
      end
      if (idx < 13)                 drive_beat(pa, idx);
      else if (idx >= 14 && idx < 27) drive_beat(pb, idx - 14);
      else trig_en = 1'b0;
    end
    chk("t4_pulses", 32'(npulse), 32'd2);
    chk("t4_first_at", 32'(first_idx), 32'd16);
    chk("t4_spacing", 32'(second_idx - first_idx), 32'd14);
    chk("t4_a_bcid", 32'(a_bcid), 32'h123);
    chk("t4_b_fields", 32'({bcid, phi_id, band_id}), 32'({12'hFFF, 5'h00, 8'h81}));
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);

    // 5. reset at beat 6, released while en=1
    fv0 = fv_n; pe0 = pe_n; le0 = le_n;
    pa = mk(12'h777, 5'h07, 8'h77, 1'b0);
    busy_seen = 1'b0;
    for (int idx = 0; idx < 22; idx++) begin
      @(negedge clk);
      if (idx == 11) busy_seen = busy;
      reset = (idx == 6 || idx == 7);
      if (idx < 13) drive_beat(pa, idx);
      else trig_en = 1'b0;
    end
    chk("t5_drain_busy", 32'(busy_seen), 32'h1);
    chk("t5_no_pulses", 32'((fv_n - fv0) + (pe_n - pe0) + (le_n - le0)), 32'd0);
    chk("t5_cnts_cleared", 32'({frame_cnt, err_cnt}), 32'h0);
    chk("t5_fields_cleared", 32'({bcid, phi_id, band_id}), 32'h0);
    send_frame(mk(12'h456, 5'h0A, 8'h3C, 1'b0), 13);
    wait_pulse(0, lat);
    chk("t5_clean_latency", 32'(lat), 32'd3);
    chk("t5_clean_fields", 32'({bcid, phi_id, band_id}), 32'({12'h456, 5'h0A, 8'h3C}));
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    idle_cycles(2);

    // 6. saturation and clear priority
    pe0 = pe_n;
    for (int f = 0; f < 17; f++) begin
      send_frame(mk(12'($urandom_range(0, 4095)), 5'h15, 8'hC3, 1'b1), 13);
      wait_pulse(1, lat);
      if (lat != 3) chk("t6_latency", 32'(lat), 32'd3);
      idle_cycles(1);
    end
    idle_cycles(2);
    chk("t6_pe_pulses", 32'(pe_n - pe0), 32'd17);
    chk("t6_err_sat", 32'(err_cnt), 32'hF);
    send_frame(mk(12'h0F0, 5'h03, 8'h0F, 1'b1), 13);
    @(negedge clk);
    @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    chk("t6_clr_pulse", 32'(parity_err), 32'h1);
    chk("t6_clr_err_cnt", 32'(err_cnt), 32'h0);
    chk("t6_clr_frame_cnt", 32'(frame_cnt), 32'h0);
    idle_cycles(2);
    send_frame(mk(12'h0F0, 5'h03, 8'h0F, 1'b1), 13);
    wait_pulse(1, lat);
    chk("t6_resume_err_cnt", 32'(err_cnt), 32'd1);
    idle_cycles(3);

    chk("one_pulse_per_cycle", 32'(viol_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
